// File: rtl/irq_pkg.sv
// Shared encodings for the interrupt controller: FSM states and config register map.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;

    localparam int STATUS_ID_LSB  = 8;
    localparam int STATUS_IRQ_BIT = 31;

endpackage

// File: rtl/irq_ctrl_if.sv
// Config bus plus cpu irq/ack/eoi handshake. master = cpu side, slave = controller.
interface irq_ctrl_if #(
    parameter int IDW = 3
) ();

    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [31:0]    cfg_wdata;
    logic [31:0]    cfg_rdata;
    logic           irq;
    logic [IDW-1:0] irq_id;
    logic           irq_ack;
    logic [IDW-1:0] ack_id;
    logic           irq_eoi;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, irq_ack, ack_id, irq_eoi,
        input  cfg_rdata, irq, irq_id
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, irq_ack, ack_id, irq_eoi,
        output cfg_rdata, irq, irq_id
    );

endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one interrupt line followed by a rising-edge detector.
// With IRQ_LEVEL_EN defined the synchronised level is passed through instead.
module irq_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic evt_o
);

    logic meta_q;
    logic sync_q;

`ifdef IRQ_LEVEL_EN
    // NOTE: sequential state uses non-blocking assignments so flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign evt_o = sync_q;
`else
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign evt_o = sync_q & ~prev_q;
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/enable registers, lowest-index priority and an
// IDLE/ASSERT/SERVICE handshake FSM. Define IRQ_LEVEL_EN for level-sensitive sources.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NSRC-1:0] src_i,
    irq_ctrl_if.slave       bus
);

    logic [NSRC-1:0] evt;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] id_onehot;
    state_e          state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  win_id;
    logic            win_valid;
    logic            ack_hit;
    logic            ack_clr;
    logic            cfg_wr_pending;
    logic            cfg_wr_enable;
    logic [31:0]     rdata;
    logic            unused_wdata;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_sync_edge u_sync (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .d_i   (src_i[g]),
            .evt_o (evt[g])
        );
    end

    assign cfg_wr_pending = bus.cfg_we && (bus.cfg_addr == REG_PENDING);
    assign cfg_wr_enable  = bus.cfg_we && (bus.cfg_addr == REG_ENABLE);
    assign unused_wdata   = ^bus.cfg_wdata;

`ifdef IRQ_LEVEL_EN
    // Pending mirrors the synchronised levels; W1C writes and acks have no effect.
    assign pending = evt;
`else
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] clr_mask;

    // Edge set is OR-ed in after the clear so a coincident edge wins.
    always_comb begin
        clr_mask = '0;
        if (cfg_wr_pending) clr_mask = bus.cfg_wdata[NSRC-1:0];
        if (ack_clr)        clr_mask = clr_mask | id_onehot;
        pending_d = (pending_q & ~clr_mask) | evt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pending_q <= '0;
        else         pending_q <= pending_d;
    end

    assign pending = pending_q;
`endif

    assign enable_d = cfg_wr_enable ? bus.cfg_wdata[NSRC-1:0] : enable_q;
    assign req      = pending & enable_q;

    // Descending scan so the last hit, the lowest index, wins.
    always_comb begin
        win_id    = '0;
        win_valid = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id    = IDW'(i);
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < NSRC; i++) begin
            id_onehot[i] = (id_q == IDW'(i));
        end
    end

    assign ack_hit = bus.irq_ack && (bus.ack_id == id_q);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = ASSERT;
                    id_d    = win_id;
                end
            end
            ASSERT: begin
                if (ack_hit) begin
                    state_d = SERVICE;
                    ack_clr = 1'b1;
                end else if (!(|(req & id_onehot))) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.irq_eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            id_q     <= '0;
            enable_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            enable_q <= enable_d;
        end
    end

    assign bus.irq    = (state_q == ASSERT);
    assign bus.irq_id = id_q;

    always_comb begin
        rdata = '0;
        case (bus.cfg_addr)
            REG_PENDING: rdata[NSRC-1:0] = pending;
            REG_ENABLE:  rdata[NSRC-1:0] = enable_q;
            REG_STATUS: begin
                rdata[1:0]                    = state_q;
                rdata[STATUS_ID_LSB +: IDW]   = id_q;
                rdata[STATUS_IRQ_BIT]         = (state_q == ASSERT);
            end
            default: rdata = '0;
        endcase
    end

    assign bus.cfg_rdata = rdata;

endmodule
